// File: rtl/dice_controller.sv
// Turn/dice stage: LFSR-driven 1..3 roll with frame-timed animation and display,
// one move command per turn, turn tracking via the player's is_moving flag.
module dice_controller #(
  parameter int unsigned ROLL_FRAMES = 30,
  parameter int unsigned SHOW_FRAMES = 20,
  parameter int unsigned ACK_TIMEOUT = 4,
  parameter int unsigned LAST_TILE   = 9,
  parameter logic [15:0] LFSR_SEED   = 16'hACE1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       frame_tick,
  input  logic       roll_btn,
  input  logic       is_moving,
  input  logic [3:0] current_tile,
  output logic       move_1,
  output logic       move_2,
  output logic       move_3,
  output logic [1:0] dice_value,
  output logic       dice_rolling,
  output logic       turn_done,
  output logic       game_over,
  output logic [7:0] turn_count
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ROLLING,
    S_SHOW,
    S_ISSUE,
    S_WAIT_DONE,
    S_GAME_OVER
  } state_t;

  localparam logic [5:0] ROLL_LAST   = 6'(ROLL_FRAMES - 1);
  localparam logic [5:0] SHOW_LAST   = 6'(SHOW_FRAMES - 1);
  localparam logic [5:0] ACK_LAST    = 6'(ACK_TIMEOUT - 1);
  localparam logic [3:0] LAST_TILE_L = 4'(LAST_TILE);

  state_t      state_q, state_d;
  logic [15:0] lfsr_q, lfsr_d;
  logic        btn_q, btn_d;
  logic [5:0]  cnt_q, cnt_d;
  logic [1:0]  result_q, result_d;
  logic [1:0]  dice_value_q, dice_value_d;
  logic        dice_rolling_q, dice_rolling_d;
  logic [2:0]  move_q, move_d;
  logic        turn_done_q, turn_done_d;
  logic        game_over_q, game_over_d;
  logic [7:0]  turn_count_q, turn_count_d;

  logic [1:0]  draw;
  logic [1:0]  face;
  logic        roll_edge;
  logic        at_last;

  // Two-stage redraw keeps the face distribution close to uniform over 1..3.
  always_comb begin
    draw = lfsr_q[1:0];
    if (draw == 2'd3) draw = lfsr_q[3:2];
    if (draw == 2'd3) draw = 2'd0;
    face = draw + 2'd1;
  end

  assign roll_edge = roll_btn & ~btn_q;
  assign at_last   = (current_tile >= LAST_TILE_L);

  always_comb begin
    state_d      = state_q;
    lfsr_d       = {1'b0, lfsr_q[15:1]} ^ (lfsr_q[0] ? 16'hB400 : 16'h0000);
    btn_d        = roll_btn;
    cnt_d        = cnt_q;
    result_d     = result_q;
    dice_value_d = dice_value_q;
    move_d       = move_q;
    turn_done_d  = 1'b0;
    turn_count_d = turn_count_q;

    case (state_q)
      S_IDLE: begin
        if (roll_edge && !is_moving && !game_over_q) begin
          state_d      = S_ROLLING;
          cnt_d        = '0;
          dice_value_d = 2'd1;
        end
      end
      S_ROLLING: begin
        if (frame_tick) begin
          if (cnt_q == ROLL_LAST) begin
            result_d     = face;
            dice_value_d = face;
            cnt_d        = '0;
            state_d      = S_SHOW;
          end else begin
            cnt_d        = cnt_q + 6'd1;
            dice_value_d = (dice_value_q == 2'd3) ? 2'd1 : dice_value_q + 2'd1;
          end
        end
      end
      S_SHOW: begin
        if (frame_tick) begin
          if (cnt_q == SHOW_LAST) begin
            cnt_d   = '0;
            state_d = S_ISSUE;
          end else begin
            cnt_d = cnt_q + 6'd1;
          end
        end
      end
      S_ISSUE: begin
        // No move is asserted only on the entry cycle: every exit clears move_q.
        if (move_q == '0) begin
          if (at_last) begin
            state_d = S_GAME_OVER;
          end else begin
            move_d = 3'b001 << (result_q - 2'd1);
            if (frame_tick) cnt_d = cnt_q + 6'd1;
          end
        end else if (is_moving) begin
          move_d  = '0;
          state_d = S_WAIT_DONE;
        end else if (frame_tick) begin
          if (cnt_q == ACK_LAST) begin
            move_d  = '0;
            cnt_d   = '0;
            state_d = S_IDLE;
          end else begin
            cnt_d = cnt_q + 6'd1;
          end
        end
      end
      S_WAIT_DONE: begin
        if (!is_moving) begin
          turn_done_d = 1'b1;
          if (turn_count_q != 8'hFF) turn_count_d = turn_count_q + 8'd1;
          state_d = at_last ? S_GAME_OVER : S_IDLE;
        end
      end
      S_GAME_OVER: begin
        move_d = '0;
      end
      default: state_d = S_IDLE;
    endcase

    dice_rolling_d = (state_d == S_ROLLING);
    game_over_d    = (state_d == S_GAME_OVER);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q        <= S_IDLE;
      lfsr_q         <= LFSR_SEED;
      btn_q          <= 1'b0;
      cnt_q          <= '0;
      result_q       <= '0;
      dice_value_q   <= '0;
      dice_rolling_q <= 1'b0;
      move_q         <= '0;
      turn_done_q    <= 1'b0;
      game_over_q    <= 1'b0;
      turn_count_q   <= '0;
    end else begin
      state_q        <= state_d;
      lfsr_q         <= lfsr_d;
      btn_q          <= btn_d;
      cnt_q          <= cnt_d;
      result_q       <= result_d;
      dice_value_q   <= dice_value_d;
      dice_rolling_q <= dice_rolling_d;
      move_q         <= move_d;
      turn_done_q    <= turn_done_d;
      game_over_q    <= game_over_d;
      turn_count_q   <= turn_count_d;
    end
  end

  assign move_1       = move_q[0];
  assign move_2       = move_q[1];
  assign move_3       = move_q[2];
  assign dice_value   = dice_value_q;
  assign dice_rolling = dice_rolling_q;
  assign turn_done    = turn_done_q;
  assign game_over    = game_over_q;
  assign turn_count   = turn_count_q;

endmodule

// File: tb/tb_dice_controller.sv
// Directed bench for dice_controller: roll/show timing, move handshake,
// ack timeout, ignored roll requests, game over and reset behaviour.
module tb_dice_controller;

  logic       clk;
  logic       rst;
  logic       frame_tick;
  logic       roll_btn;
  logic       is_moving;
  logic [3:0] current_tile;
  logic       move_1, move_2, move_3;
  logic [1:0] dice_value;
  logic       dice_rolling;
  logic       turn_done;
  logic       game_over;
  logic [7:0] turn_count;

  logic [2:0]  moves;
  logic [15:0] lfsr_m;
  logic [15:0] tick_lfsr;
  logic [1:0]  face;
  int unsigned checks;
  int unsigned errors;

  dice_controller #(
    .ROLL_FRAMES(30),
    .SHOW_FRAMES(20),
    .ACK_TIMEOUT(4),
    .LAST_TILE  (9),
    .LFSR_SEED  (16'hACE1)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .frame_tick  (frame_tick),
    .roll_btn    (roll_btn),
    .is_moving   (is_moving),
    .current_tile(current_tile),
    .move_1      (move_1),
    .move_2      (move_2),
    .move_3      (move_3),
    .dice_value  (dice_value),
    .dice_rolling(dice_rolling),
    .turn_done   (turn_done),
    .game_over   (game_over),
    .turn_count  (turn_count)
  );

  assign moves = {move_3, move_2, move_1};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference Galois LFSR, free-running alongside the DUT.
  always @(posedge clk or posedge rst) begin
    if (rst) lfsr_m <= 16'hACE1;
    else     lfsr_m <= {1'b0, lfsr_m[15:1]} ^ (lfsr_m[0] ? 16'hB400 : 16'h0000);
  end

  function automatic logic [1:0] exp_face(input logic [15:0] l);
    logic [1:0] v;
    v = l[1:0];
    if (v == 2'd3) v = l[3:2];
    if (v == 2'd3) v = 2'd0;
    return v + 2'd1;
  endfunction

  function automatic logic [2:0] onehot(input logic [1:0] f);
    case (f)
      2'd1:    return 3'b001;
      2'd2:    return 3'b010;
      2'd3:    return 3'b100;
      default: return 3'b000;
    endcase
  endfunction

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    frame_tick = 1'b1;
    tick_lfsr  = lfsr_m;
    @(negedge clk);
    frame_tick = 1'b0;
  endtask

  // Rest of a 10-clk frame, with a roll_btn pulse that must be ignored.
  task automatic pad9();
    roll_btn = 1'b1;
    @(negedge clk);
    roll_btn = 1'b0;
    repeat (8) @(negedge clk);
  endtask

  // Accepted roll through ROLLING and SHOW; returns on the ISSUE entry cycle.
  task automatic roll_and_show(output logic [1:0] f);
    roll_btn = 1'b1;
    @(negedge clk);
    roll_btn = 1'b0;
    chk("roll_start_rolling", 16'(dice_rolling), 16'd1);
    chk("roll_start_value", 16'(dice_value), 16'd1);
    f = 2'd0;
    for (int k = 1; k <= 30; k++) begin
      tick();
      if (k < 30) begin
        chk("rolling_flag", 16'(dice_rolling), 16'd1);
        chk("rolling_value", 16'(dice_value), 16'((k % 3) + 1));
      end else begin
        f = exp_face(tick_lfsr);
        chk("roll_end_flag", 16'(dice_rolling), 16'd0);
        chk("roll_end_face", 16'(dice_value), 16'(f));
      end
      pad9();
    end
    for (int k = 1; k <= 20; k++) begin
      tick();
      if (k < 20) begin
        chk("show_no_move", 16'(moves), 16'd0);
        chk("show_value", 16'(dice_value), 16'(f));
        pad9();
      end
    end
    chk("issue_entry_no_move", 16'(moves), 16'd0);
  endtask

  initial begin
    checks       = 0;
    errors       = 0;
    rst          = 1'b1;
    frame_tick   = 1'b0;
    roll_btn     = 1'b0;
    is_moving    = 1'b0;
    current_tile = 4'd0;
    tick_lfsr    = '0;
    face         = '0;

    repeat (3) @(negedge clk);
    chk("rst_moves", 16'(moves), 16'd0);
    chk("rst_dice_value", 16'(dice_value), 16'd0);
    chk("rst_rolling", 16'(dice_rolling), 16'd0);
    chk("rst_turn_done", 16'(turn_done), 16'd0);
    chk("rst_game_over", 16'(game_over), 16'd0);
    chk("rst_turn_count", 16'(turn_count), 16'd0);
    rst = 1'b0;
    @(negedge clk);
    chk("post_rst_moves", 16'(moves), 16'd0);
    chk("post_rst_rolling", 16'(dice_rolling), 16'd0);

    // Full turn with a responsive player.
    roll_and_show(face);
    @(negedge clk);
    chk("t1_move", 16'(moves), 16'(onehot(face)));
    @(negedge clk);
    chk("t1_move_held", 16'(moves), 16'(onehot(face)));
    is_moving = 1'b1;
    @(negedge clk);
    chk("t1_move_drop", 16'(moves), 16'd0);
    chk("t1_no_done_yet", 16'(turn_done), 16'd0);
    roll_btn = 1'b1;
    @(negedge clk);
    roll_btn = 1'b0;
    chk("t1_wait_roll_ignored", 16'(dice_rolling), 16'd0);
    repeat (40 * int'(face) * 10) @(negedge clk);
    chk("t1_wait_no_move", 16'(moves), 16'd0);
    is_moving = 1'b0;
    roll_btn  = 1'b1;
    @(negedge clk);
    chk("t1_turn_done", 16'(turn_done), 16'd1);
    chk("t1_turn_count", 16'(turn_count), 16'd1);
    chk("t1_exit_roll_dropped", 16'(dice_rolling), 16'd0);
    @(negedge clk);
    chk("t1_turn_done_pulse", 16'(turn_done), 16'd0);
    chk("t1_held_btn_no_roll", 16'(dice_rolling), 16'd0);
    roll_btn = 1'b0;
    @(negedge clk);

    // Roll request while the player is still busy.
    is_moving = 1'b1;
    @(negedge clk);
    roll_btn = 1'b1;
    @(negedge clk);
    chk("busy_roll_ignored", 16'(dice_rolling), 16'd0);
    roll_btn  = 1'b0;
    is_moving = 1'b0;
    @(negedge clk);
    chk("busy_roll_not_queued", 16'(dice_rolling), 16'd0);

    // No acknowledgement from the player: move times out after 4 frames.
    roll_and_show(face);
    @(negedge clk);
    chk("t2_move", 16'(moves), 16'(onehot(face)));
    for (int t = 1; t <= 4; t++) begin
      tick();
      if (t < 4) begin
        chk("t2_move_held", 16'(moves), 16'(onehot(face)));
        pad9();
      end
    end
    chk("t2_timeout_drop", 16'(moves), 16'd0);
    chk("t2_no_turn_done", 16'(turn_done), 16'd0);
    chk("t2_count_same", 16'(turn_count), 16'd1);
    chk("t2_value_kept", 16'(dice_value), 16'(face));
    repeat (3) @(negedge clk);
    chk("t2_idle_no_move", 16'(moves), 16'd0);

    // Player reaches the last tile during this turn.
    current_tile = 4'd8;
    roll_and_show(face);
    @(negedge clk);
    chk("t3_move", 16'(moves), 16'(onehot(face)));
    is_moving = 1'b1;
    @(negedge clk);
    chk("t3_move_drop", 16'(moves), 16'd0);
    repeat (20) @(negedge clk);
    is_moving    = 1'b0;
    current_tile = 4'd9;
    @(negedge clk);
    chk("t3_game_over", 16'(game_over), 16'd1);
    chk("t3_turn_done", 16'(turn_done), 16'd1);
    chk("t3_turn_count", 16'(turn_count), 16'd2);
    @(negedge clk);
    chk("t3_turn_done_pulse", 16'(turn_done), 16'd0);
    chk("t3_game_over_sticky", 16'(game_over), 16'd1);
    for (int t = 0; t < 3; t++) begin
      tick();
      pad9();
      chk("go_no_rolling", 16'(dice_rolling), 16'd0);
      chk("go_no_move", 16'(moves), 16'd0);
    end
    chk("go_still_over", 16'(game_over), 16'd1);
    rst = 1'b1;
    #1;
    chk("go_rst_game_over", 16'(game_over), 16'd0);
    chk("go_rst_turn_count", 16'(turn_count), 16'd0);
    chk("go_rst_dice_value", 16'(dice_value), 16'd0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // Already on the last tile when the move would be issued.
    roll_and_show(face);
    @(negedge clk);
    chk("t4_game_over", 16'(game_over), 16'd1);
    chk("t4_no_move", 16'(moves), 16'd0);
    chk("t4_no_turn_done", 16'(turn_done), 16'd0);
    chk("t4_count_zero", 16'(turn_count), 16'd0);

    // Reset while a move command is asserted.
    rst = 1'b1;
    @(negedge clk);
    rst          = 1'b0;
    current_tile = 4'd0;
    @(negedge clk);
    roll_and_show(face);
    @(negedge clk);
    chk("t5_move", 16'(moves), 16'(onehot(face)));
    rst = 1'b1;
    #1;
    chk("t5_rst_moves", 16'(moves), 16'd0);
    chk("t5_rst_value", 16'(dice_value), 16'd0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("t5_after_rst_moves", 16'(moves), 16'd0);
    chk("t5_after_rst_rolling", 16'(dice_rolling), 16'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
